up_down_counter: RTL and testbench
==================================

// Module: up_down_counter
// PURPOSE
//   8-bit programmable up/down counter with a microprocessor-style register port.
//   A host writes four registers (PLR, ULR, LLR, CCR) over a shared bidirectional data bus.
//   The host uses chip select, read/write strobes and address A1:A0.
//   Once started, the counter runs between the lower and upper limits and flags end-of-count.
//   It also flags illegal configurations.
// PARAMETERS
//   none (all widths fixed at 8 bits)
// PORTS
//   clk    in     1  system clock, all state changes on posedge
//   reset  in     1  asynchronous, active-low reset (one clock; reset is async active-low)
//   din    inout  8  host data bus: written into registers, driven with register data on read
//   ncs    in     1  chip select, active low
//   nrd    in     1  read strobe, active low
//   nwr    in     1  write strobe, active low
//   start  in     1  count enable, level sensitive, active high
//   A0     in     1  register address bit 0
//   A1     in     1  register address bit 1
//   count  out    8  current counter value
//   err    out    1  configuration/bus error flag
//   ec     out    1  end-of-count pulse
//   dir    out    1  current count direction: 0=up, 1=down
// BEHAVIOUR
//   Register map (A1A0):
//     00 PLR  preload value
//     01 ULR  upper limit
//     10 LLR  lower limit
//     11 CCR  control
//   CCR[1:0] mode:
//     00 up; 01 down
//     10 bounce, starting up; 11 bounce, starting down
//   CCR[2]: 0 continuous, 1 one-shot. CCR[7:3] are stored and read back but have no effect.
//   Reset (reset=0, async):
//     PLR=0, ULR=8'hFF, LLR=0, CCR=0
//     count=0, err=0, ec=0, dir=0
//     din released (Z)
//   Write: at posedge clk with ncs=0, nwr=0, nrd!=0, din is stored in register A1A0.
//     The last write wins; back-to-back writes take one cycle each.
//   Read: with ncs=0, nrd=0, nwr=1, din is driven combinationally with register A1A0.
//     In all other cases din is Z.
//   Bus conflict: ncs=0 with nrd=0 and nwr=0.
//     No write occurs, din stays Z, and err is set.
//   Config error: evaluated every posedge from the register values.
//     Error when LLR>=ULR, or PLR<LLR, or PLR>ULR.
//     err is registered (1-cycle latency after the offending write).
//     err clears when the config becomes legal and no bus conflict occurs that cycle.
//   While err=1 the count holds its value and ec=0.
//   Counting:
//     Rising edge of start (registered compare): count<=PLR, and dir<=CCR[0].
//     While start=1 and err=0, count steps by 1 each clock in direction dir.
//     Up reaching ULR, or down reaching LLR, asserts ec for exactly one cycle (the cycle count==limit).
//     At the limit, continuous up: next count=LLR (wrap). Continuous down: next count=ULR.
//     At the limit, bounce mode: dir toggles and counting reverses.
//       Up: ULR -> ULR-1. Down: LLR -> LLR+1.
//     One-shot mode: count holds at the limit until the next start rising edge.
//   start=0: count holds its value and dir holds.
//   Register writes during counting take effect on the next cycle.
//     A count already outside the new limits is loaded with PLR on the next step.
//   Reset mid-count: everything returns to the reset values immediately.
// CONFIGURATION
//   COUNT_READBACK_EN defined: a read at A1A0=00 returns the live count instead of PLR.
//     Writes to address 00 still load PLR.
//   COUNT_READBACK_EN undefined: address 00 reads PLR.
// TESTING
//   1. Assert reset=0, then 1.
//      -> count=0, err=0, ec=0, dir=0.
//      -> Reads return PLR=0, ULR=8'hFF, LLR=0, CCR=0.
//   2. Write PLR=20, ULR=15, LLR=5, CCR=2.
//      -> err=1, since PLR>ULR.
//      -> Then rewrite PLR=10 -> err=0 one cycle later.
//      -> Readback gives 10/15/5/2.
//   3. PLR=10, ULR=15, LLR=5, CCR=0, start 0->1.
//      -> count 10,11,...,15, with ec=1 at 15.
//      -> Then count goes to 5,6,... (wrap).
//   4. Same config with CCR=2 (bounce).
//      -> count ...14,15,14,...,5,6.
//      -> dir toggles at 15 and at 5; ec pulses at both.
//   5. CCR=5 (down, one-shot), PLR=7, start 0->1.
//      -> count 7,6,5 and holds at 5, with a single ec pulse.
//   6. ncs=0, nrd=0, nwr=0 with din=8'h33.
//      -> No register changes, din is Z, err=1.
//      -> Release the strobes -> err=0 on the next cycle.

Source files
------------

// File: rtl/up_down_counter.sv
// ---------------------------------------------------------------------------
// up_down_counter
//   8-bit programmable up/down counter behind a microprocessor-style register
//   port. The host writes four registers (PLR, ULR, LLR, CCR) and reads them
//   back over a shared bidirectional bus. A level-sensitive start runs the
//   counter between LLR and ULR. The block flags end-of-count and flags
//   illegal configurations or bus conflicts.
//
// Ports
//   clk    in     system clock, all state changes on posedge
//   reset  in     asynchronous active-low reset
//   din    inout  8-bit host data bus (written on nwr, driven on nrd)
//   ncs    in     chip select, active low
//   nrd    in     read strobe, active low
//   nwr    in     write strobe, active low
//   start  in     count enable, level sensitive, active high
//   A0/A1  in     register address (00 PLR, 01 ULR, 10 LLR, 11 CCR)
//   count  out    current counter value
//   err    out    configuration / bus-conflict error flag (registered)
//   ec     out    end-of-count flag, high during the cycle count==limit
//   dir    out    current direction, 0=up 1=down
//
// Build option
//   COUNT_READBACK_EN : when defined, a read at address 00 returns the live
//                       count instead of PLR. Writes to 00 still load PLR.
// ---------------------------------------------------------------------------
module up_down_counter (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] din,
  input  logic       ncs,
  input  logic       nrd,
  input  logic       nwr,
  input  logic       start,
  input  logic       A0,
  input  logic       A1,
  output logic [7:0] count,
  output logic       err,
  output logic       ec,
  output logic       dir
);

  localparam logic [1:0] ADDR_PLR = 2'b00;
  localparam logic [1:0] ADDR_ULR = 2'b01;
  localparam logic [1:0] ADDR_LLR = 2'b10;
  localparam logic [1:0] ADDR_CCR = 2'b11;

  logic [7:0] plr_q, plr_d;
  logic [7:0] ulr_q, ulr_d;
  logic [7:0] llr_q, llr_d;
  logic [7:0] ccr_q, ccr_d;
  logic [7:0] count_q, count_d;
  logic       dir_q, dir_d;
  logic       ec_q, ec_d;
  logic       err_q, err_d;
  logic       start_q;

  logic [1:0] addr_s;
  logic       wr_s;
  logic       rd_s;
  logic       conflict_s;
  logic       moved_s;
  logic [7:0] rd_data_s;

  // Illegal configuration: empty/inverted window or preload outside it.
  function automatic logic cfg_bad(input logic [7:0] plr, input logic [7:0] ulr,
                                   input logic [7:0] llr);
    cfg_bad = (llr >= ulr) || (plr < llr) || (plr > ulr);
  endfunction

  assign addr_s     = {A1, A0};
  assign wr_s       = ~ncs & ~nwr &  nrd;
  assign rd_s       = ~ncs & ~nrd &  nwr;
  assign conflict_s = ~ncs & ~nrd & ~nwr;

  // Register file next-state and error flag.
  always_comb begin
    plr_d = plr_q;
    ulr_d = ulr_q;
    llr_d = llr_q;
    ccr_d = ccr_q;
    if (wr_s) begin
      case (addr_s)
        ADDR_PLR: plr_d = din;
        ADDR_ULR: ulr_d = din;
        ADDR_LLR: llr_d = din;
        ADDR_CCR: ccr_d = din;
        default:  plr_d = plr_q;
      endcase
    end else begin
      plr_d = plr_q;
    end
    // Judged on the current register contents, so err lags a bad write by one cycle.
    err_d = cfg_bad(plr_q, ulr_q, llr_q) | conflict_s;
  end

  // Counter next-state: load on start rising edge, then step / wrap / bounce / hold.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    moved_s = 1'b0;
    if (err_q) begin
      count_d = count_q;
    end else if (start && !start_q) begin
      count_d = plr_q;
      dir_d   = ccr_q[0];
      moved_s = 1'b1;
    end else if (start) begin
      if ((count_q < llr_q) || (count_q > ulr_q)) begin
        // Limits moved under a running count: restart from the preload.
        count_d = plr_q;
        moved_s = 1'b1;
      end else if (!dir_q) begin
        if (count_q == ulr_q) begin
          if (ccr_q[2]) begin
            count_d = count_q;
          end else if (ccr_q[1]) begin
            count_d = ulr_q - 8'd1;
            dir_d   = 1'b1;
            moved_s = 1'b1;
          end else begin
            count_d = llr_q;
            moved_s = 1'b1;
          end
        end else begin
          count_d = count_q + 8'd1;
          moved_s = 1'b1;
        end
      end else begin
        if (count_q == llr_q) begin
          if (ccr_q[2]) begin
            count_d = count_q;
          end else if (ccr_q[1]) begin
            count_d = llr_q + 8'd1;
            dir_d   = 1'b0;
            moved_s = 1'b1;
          end else begin
            count_d = ulr_q;
            moved_s = 1'b1;
          end
        end else begin
          count_d = count_q - 8'd1;
          moved_s = 1'b1;
        end
      end
    end else begin
      count_d = count_q;
    end
    // Only a move onto the limit flags ec, so a one-shot hold gives a single pulse.
    if (moved_s) begin
      ec_d = dir_d ? (count_d == llr_q) : (count_d == ulr_q);
    end else begin
      ec_d = 1'b0;
    end
  end

  // Read-back multiplexer.
  always_comb begin
    case (addr_s)
`ifdef COUNT_READBACK_EN
      ADDR_PLR: rd_data_s = count_q;
`else
      ADDR_PLR: rd_data_s = plr_q;
`endif
      ADDR_ULR: rd_data_s = ulr_q;
      ADDR_LLR: rd_data_s = llr_q;
      ADDR_CCR: rd_data_s = ccr_q;
      default:  rd_data_s = 8'h00;
    endcase
  end

  assign din = rd_s ? rd_data_s : 8'bzzzz_zzzz;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plr_q   <= 8'h00;
      ulr_q   <= 8'hFF;
      llr_q   <= 8'h00;
      ccr_q   <= 8'h00;
      count_q <= 8'h00;
      dir_q   <= 1'b0;
      ec_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      plr_q   <= plr_d;
      ulr_q   <= ulr_d;
      llr_q   <= llr_d;
      ccr_q   <= ccr_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      ec_q    <= ec_d;
      err_q   <= err_d;
      start_q <= start;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign ec    = ec_q;
  assign err   = err_q;

endmodule

// File: tb/tb_up_down_counter.sv
module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       ncs, nrd, nwr, start, A0, A1;
  logic       tb_oe;
  logic [7:0] tb_data;
  wire  [7:0] din;
  logic [7:0] count;
  logic       err, ec, dir;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       start;
    logic [7:0] count;
    logic       ec;
    logic       dir;
  } vec_t;

  vec_t vecs[$];

  assign din = tb_oe ? tb_data : 8'bzzzz_zzzz;

  up_down_counter dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .ncs   (ncs),
    .nrd   (nrd),
    .nwr   (nwr),
    .start (start),
    .A0    (A0),
    .A1    (A1),
    .count (count),
    .err   (err),
    .ec    (ec),
    .dir   (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, count=%0d expected end of test", count);
    $fatal(1, "watchdog");
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    {A1, A0} = a;
    tb_data  = d;
    tb_oe    = 1'b1;
    ncs      = 1'b0;
    nwr      = 1'b0;
    nrd      = 1'b1;
    @(posedge clk);
    #1;
    ncs   = 1'b1;
    nwr   = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    {A1, A0} = a;
    ncs = 1'b0;
    nrd = 1'b0;
    nwr = 1'b1;
    #1;
    d   = din;
    ncs = 1'b1;
    nrd = 1'b1;
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] p, input logic [7:0] u,
                            input logic [7:0] l, input logic [7:0] c);
    logic [7:0] r;
    bus_read(2'b00, r); check8({tag, " PLR"}, r, p);
    bus_read(2'b01, r); check8({tag, " ULR"}, r, u);
    bus_read(2'b10, r); check8({tag, " LLR"}, r, l);
    bus_read(2'b11, r); check8({tag, " CCR"}, r, c);
  endtask

  task automatic add_vec(input logic s, input logic [7:0] c, input logic e, input logic d);
    vec_t v;
    v.start = s;
    v.count = c;
    v.ec    = e;
    v.dir   = d;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      tick();
      check8($sformatf("%s[%0d] count", tag, i), count, vecs[i].count);
      check1($sformatf("%s[%0d] ec", tag, i), ec, vecs[i].ec);
      check1($sformatf("%s[%0d] dir", tag, i), dir, vecs[i].dir);
    end
    vecs.delete();
  endtask

  task automatic step_check(input string tag, input logic [7:0] c, input logic e,
                            input logic d);
    tick();
    check8({tag, " count"}, count, c);
    check1({tag, " ec"}, ec, e);
    check1({tag, " dir"}, dir, d);
  endtask

  initial begin
    reset = 1'b0; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; start = 1'b0;
    A0 = 1'b0; A1 = 1'b0; tb_oe = 1'b0; tb_data = 8'h00;

    // 1. Reset values
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    check8("reset count", count, 8'd0);
    check1("reset err", err, 1'b0);
    check1("reset ec", ec, 1'b0);
    check1("reset dir", dir, 1'b0);
    check_regs("reset", 8'h00, 8'hFF, 8'h00, 8'h00);

    // 2. Illegal config (PLR>ULR), then repair PLR
    bus_write(2'b00, 8'd20);
    bus_write(2'b01, 8'd15);
    bus_write(2'b10, 8'd5);
    bus_write(2'b11, 8'd2);
    check1("cfg err set", err, 1'b1);
    bus_write(2'b00, 8'd10);
    check1("cfg err latency", err, 1'b1);
    tick();
    check1("cfg err cleared", err, 1'b0);
    check_regs("cfg", 8'd10, 8'd15, 8'd5, 8'd2);

    // 3. Continuous up with wrap to LLR
    bus_write(2'b11, 8'd0);
    add_vec(1'b1, 8'd10, 1'b0, 1'b0);
    add_vec(1'b1, 8'd11, 1'b0, 1'b0);
    add_vec(1'b1, 8'd12, 1'b0, 1'b0);
    add_vec(1'b1, 8'd13, 1'b0, 1'b0);
    add_vec(1'b1, 8'd14, 1'b0, 1'b0);
    add_vec(1'b1, 8'd15, 1'b1, 1'b0);
    add_vec(1'b1, 8'd5,  1'b0, 1'b0);
    add_vec(1'b1, 8'd6,  1'b0, 1'b0);
    add_vec(1'b1, 8'd7,  1'b0, 1'b0);
    add_vec(1'b0, 8'd7,  1'b0, 1'b0);
    run_vecs("up");

    // 4. Bounce starting up
    bus_write(2'b11, 8'd2);
    add_vec(1'b1, 8'd10, 1'b0, 1'b0);
    for (int k = 11; k <= 14; k++) add_vec(1'b1, 8'(k), 1'b0, 1'b0);
    add_vec(1'b1, 8'd15, 1'b1, 1'b0);
    for (int k = 14; k >= 6; k--) add_vec(1'b1, 8'(k), 1'b0, 1'b1);
    add_vec(1'b1, 8'd5,  1'b1, 1'b1);
    add_vec(1'b1, 8'd6,  1'b0, 1'b0);
    add_vec(1'b1, 8'd7,  1'b0, 1'b0);
    add_vec(1'b0, 8'd7,  1'b0, 1'b0);
    run_vecs("bounce");

    // 5. Down, one-shot: single ec then hold at LLR
    bus_write(2'b11, 8'd5);
    bus_write(2'b00, 8'd7);
    check1("oneshot cfg err", err, 1'b0);
    start = 1'b1;
    step_check("oneshot 7", 8'd7, 1'b0, 1'b1);
    step_check("oneshot 6", 8'd6, 1'b0, 1'b1);
    step_check("oneshot 5", 8'd5, 1'b1, 1'b1);
    step_check("oneshot hold1", 8'd5, 1'b0, 1'b1);
    step_check("oneshot hold2", 8'd5, 1'b0, 1'b1);
    start = 1'b0;
    tick();

    // 6. Bus conflict: no write, bus not driven by DUT, err set then cleared
    {A1, A0} = 2'b00;
    tb_data = 8'h33; tb_oe = 1'b1;
    ncs = 1'b0; nrd = 1'b0; nwr = 1'b0;
    #1;
    check8("conflict din", din, 8'h33);
    tick();
    check1("conflict err", err, 1'b1);
    check8("conflict count hold", count, 8'd5);
    ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; tb_oe = 1'b0;
    tick();
    check1("conflict err cleared", err, 1'b0);
    check_regs("conflict", 8'd7, 8'd15, 8'd5, 8'd5);

    // Limits shrink under a running count: reload from PLR on next step
    bus_write(2'b00, 8'd10);
    bus_write(2'b11, 8'd0);
    start = 1'b1;
    step_check("shrink 10", 8'd10, 1'b0, 1'b0);
    step_check("shrink 11", 8'd11, 1'b0, 1'b0);
    step_check("shrink 12", 8'd12, 1'b0, 1'b0);
    bus_write(2'b01, 8'd12);
    check8("shrink step during write", count, 8'd13);
    step_check("shrink reload", 8'd10, 1'b0, 1'b0);
    step_check("shrink 11b", 8'd11, 1'b0, 1'b0);
    step_check("shrink ec", 8'd12, 1'b1, 1'b0);
    step_check("shrink wrap", 8'd5, 1'b0, 1'b0);
    start = 1'b0;
    tick();

    // Reset mid-count takes effect immediately
    start = 1'b1;
    step_check("midrst 10", 8'd10, 1'b0, 1'b0);
    step_check("midrst 11", 8'd11, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check8("midrst count", count, 8'd0);
    check1("midrst dir", dir, 1'b0);
    check1("midrst err", err, 1'b0);
    check1("midrst ec", ec, 1'b0);
    start = 1'b0;
    check_regs("midrst", 8'h00, 8'hFF, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    check8("after reset count", count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
